// File: rtl/softmax_exp_sum_buffer.sv
// softmax_exp_sum_buffer: buffers one vector of exponent values, sums them, presents the sum, then replays the values.
// Ports: clk/rst (async active-low); in_valid/in_data/in_last/in_ready upstream;
// sum_valid/sum_data/sum_ready to the divider; out_valid/out_data/out_last/out_ready replay;
// overflow/drop sticky error flags.
module softmax_exp_sum_buffer #(
  parameter int BITS = 15,
  parameter int DEPTH = 16,
  parameter int SUM_BITS = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [BITS:0]       in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                sum_valid,
  output logic [SUM_BITS:0]   sum_data,
  input  logic                sum_ready,
  output logic                out_valid,
  output logic [BITS:0]       out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                overflow,
  output logic                drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {ACCUM, SUM, REPLAY} state_t;
  state_t state, state_nx;
  logic [BITS:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_ptr;
  logic [SUM_BITS:0] sum;
  logic accept, full, last;
  assign accept = in_valid && state == ACCUM;
  assign full = cnt == CW'(DEPTH - 1);
  assign last = {1'b0, rd_ptr} == cnt - CW'(1);
  assign in_ready = state == ACCUM;
  assign sum_valid = state == SUM;
  assign sum_data = sum;
  assign out_valid = state == REPLAY;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign out_last = out_valid && last;
  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:   state_nx = (in_valid && (in_last || full)) ? SUM : ACCUM;
      SUM:     state_nx = sum_ready ? REPLAY : SUM;
      REPLAY:  state_nx = (out_ready && last) ? ACCUM : REPLAY;
      default: state_nx = ACCUM;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
      mem <= '{default: '0};
      cnt <= '0;
      rd_ptr <= '0;
      sum <= '0;
      overflow <= 1'b0;
      drop <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_valid && state != ACCUM) drop <= 1'b1;
      if (accept) begin
        mem[cnt[AW-1:0]] <= in_data;
        sum <= sum + (SUM_BITS + 1)'(in_data);
        cnt <= cnt + CW'(1);
        if (full && !in_last) overflow <= 1'b1;
      end
      if (state == SUM && sum_ready) rd_ptr <= '0;
      if (state == REPLAY && out_ready) begin
        if (last) begin
          cnt <= '0;
          sum <= '0;
          rd_ptr <= '0;
        end else rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_softmax_exp_sum_buffer.sv
// tb_softmax_exp_sum_buffer: directed self-checking bench for softmax_exp_sum_buffer.
module tb_softmax_exp_sum_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, sum_ready = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, sum_valid, out_valid, out_last, overflow, drop;
  logic [19:0] sum_data;
  logic [15:0] out_data;
  int checks = 0;
  int errors = 0;
  logic [15:0] vec [4] = '{16'h1000, 16'h2000, 16'h0800, 16'h0001};
  softmax_exp_sum_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .sum_valid(sum_valid), .sum_data(sum_data), .sum_ready(sum_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .overflow(overflow), .drop(drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic take_sum();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk("out_valid_after_sum", {31'd0, out_valid}, 32'd1);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      in_data = 16'($urandom);
      in_last = 1'($urandom);
      sum_ready = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_others", {26'd0, sum_valid, out_valid, out_last, overflow, drop, |sum_data}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    sum_ready = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("idle_stable", {25'd0, in_ready, sum_valid, out_valid, out_last, overflow, drop, |sum_data}, 32'h40);
    for (int i = 0; i < 4; i++) send(vec[i], i == 3);
    chk("basic_sum_valid", {30'd0, sum_valid, in_ready}, 32'h2);
    chk("basic_sum", {12'd0, sum_data}, 32'h03801);
    take_sum();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("basic_data", {16'd0, out_data}, {16'd0, vec[i]});
      chk("basic_last", {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    out_ready = 1'b0;
    chk("basic_return", {29'd0, in_ready, out_valid, sum_valid}, 32'h4);
    chk("basic_sum_clear", {12'd0, sum_data}, 32'd0);
    for (int i = 0; i < 4; i++) send(vec[i], i == 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum_hold", {11'd0, sum_valid, sum_data}, 32'h103801);
      tick();
    end
    take_sum();
    begin
      int k = 0;
      for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
        out_ready = cyc[0];
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_data", {16'd0, out_data}, {16'd0, vec[k]});
        chk("bp_last", {31'd0, out_last}, (k == 3) ? 32'd1 : 32'd0);
        if (out_ready) k++;
        tick();
      end
      out_ready = 1'b0;
      chk("bp_handshakes", k, 32'd4);
    end
    chk("bp_return", {30'd0, in_ready, out_valid}, 32'h2);
    for (int i = 0; i < 16; i++) send(16'hFFFF, 1'b0);
    chk("ovf_sum_valid", {31'd0, sum_valid}, 32'd1);
    chk("ovf_sum", {12'd0, sum_data}, 32'hFFFF0);
    chk("ovf_flags", {30'd0, overflow, drop}, 32'h2);
    send(16'hFFFF, 1'b0);
    chk("ovf_drop", {30'd0, overflow, drop}, 32'h3);
    chk("ovf_sum_kept", {11'd0, sum_valid, sum_data}, 32'h1FFFF0);
    take_sum();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_data", {15'd0, out_valid, out_data}, 32'h1FFFF);
      chk("ovf_last", {31'd0, out_last}, (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_return", {31'd0, in_ready}, 32'd1);
    send(16'hABCD, 1'b1);
    chk("single_sum", {11'd0, sum_valid, sum_data}, 32'h10ABCD);
    take_sum();
    chk("single_out", {15'd0, out_last, out_data}, 32'h1ABCD);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_return", {30'd0, in_ready, out_valid}, 32'h2);
    for (int i = 0; i < 4; i++) send(vec[i], i == 3);
    take_sum();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("mid_third", {16'd0, out_data}, 32'h0800);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst", {26'd0, in_ready, out_valid, sum_valid, overflow, drop, |sum_data}, 32'h20);
    #1 rst = 1'b1;
    tick();
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b1);
    chk("mid_new_sum", {11'd0, sum_valid, sum_data}, 32'h100003);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/softmax_exp_sum_buffer.md
# softmax_exp_sum_buffer

- Sits directly downstream of the 3-cycle 16-bit alignment delay in the softmax datapath.
- Accepts one vector of exponent values per pass, stores each value in a local flop buffer, and accumulates their sum.
- At end of vector, presents the sum to the divider stage, then replays the stored values in order under ready/valid backpressure.
- Gives the normaliser both the denominator and the numerators without re-running the exponent pipeline.

## Interface
Parameters:
- BITS, 15, data MSB index; data width is BITS+1.
- DEPTH, 16, max elements per vector; power of two, 2..256.
- SUM_BITS, 19, sum MSB index; must satisfy SUM_BITS ≥ BITS + log2(DEPTH), so the sum can never overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  element present; delayed alongside data, no backpressure upstream.
- in_data  in  BITS+1  exponent value.
- in_last  in  1  final element of the vector.
- in_ready  out  1  high only in state ACCUM.
- sum_valid  out  1  sum available.
- sum_data  out  SUM_BITS+1  unsigned sum of the vector.
- sum_ready  in  1  divider accepts the sum.
- out_valid  out  1  replay element present.
- out_data  out  BITS+1  replayed value.
- out_last  out  1  final replayed element.
- out_ready  in  1  consumer accepts the replayed element.
- overflow  out  1  sticky: vector exceeded DEPTH.
- drop  out  1  sticky: in_valid arrived while in_ready was low.

## Operation
- Internal state: a flop array buf[DEPTH]; wr count cnt (0..DEPTH); rd_ptr; sum register.
- Three-state FSM:
  - ACCUM: in_ready=1. On in_valid: buf[cnt]<=in_data, sum<=sum+in_data (zero-extended, unsigned), cnt<=cnt+1.
    - If in_last, or the accepted element is the DEPTH-th: go to SUM.
    - If the DEPTH-th element arrives with in_last=0: overflow<=1; the vector is forcibly terminated.
  - SUM: sum_valid=1, sum_data=sum. On sum_ready: go to REPLAY, rd_ptr<=0.
  - REPLAY: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==cnt-1).
    - On out_ready and not last: rd_ptr+1.
    - On out_ready and last: go to ACCUM; cnt, sum and rd_ptr clear to 0.
- in_valid while not in ACCUM: element discarded; drop<=1; state and sum unchanged.
- in_last with cnt reaching exactly DEPTH: normal termination, overflow stays 0.
- Empty vectors cannot occur: termination always follows an accepted element.
- overflow and drop clear only on reset.
- sum_data and out_data/out_last stay stable while their valid is high and ready is low.

## Timing
- Reset (rst low, asynchronous): state=ACCUM, buf/cnt/sum/rd_ptr=0.
  - Output values: in_ready=1, sum_valid=0, sum_data=0, out_valid=0, out_data=0, out_last=0, overflow=0, drop=0.
- Ready and valid outputs decode from registered state; out_data is a combinational mux of buf by rd_ptr.
- Last element accepted at edge t: sum_valid high from t+1; in_ready low from t+1.
- Sum handshake at edge s: out_valid high from s+1.
- With out_ready held high, N elements replay in N cycles.
- Final replay handshake at edge r: in_ready high from r+1, with sum=0.
- Minimum turnaround per N-element vector with ready inputs held high: N + 1 + N cycles.
- Reset mid-operation: immediate return to the reset values above; any partial vector is lost.

## Test plan
- Reset check: hold rst low with random inputs → in_ready=1 and every other output 0. Release → no outputs change until in_valid.
- Basic vector: in_data 0x1000, 0x2000, 0x0800, 0x0001 (last on 4th) → next cycle sum_valid=1, sum_data=0x03801. Assert sum_ready → replay in order; out_last only on 0x0001; in_ready returns.
- Backpressure: same vector with sum_ready delayed 5 cycles and out_ready toggling every cycle → sum_data and out_data held stable while stalled; exactly 4 handshakes; order preserved.
- Overflow: 17 consecutive 0xFFFF with no in_last → 16 buffered, sum_data=0xFFFF0, overflow=1, out_last on 16th replay. 17th element arrives in SUM → drop=1.
- Single element: 0xABCD with in_last → sum_data=0x0ABCD; one replay with out_last=1, out_data=0xABCD.
- Reset mid-replay: assert rst after 2 of 4 replays → out_valid=0, in_ready=1, flags 0. A new 2-element vector 0x0001, 0x0002 → sum_data=0x00003.
